// File: rtl/imem_pkg.sv
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared types and constants for the instruction-memory loader.
//           Macro IMEM_LOADER_READBACK_EN adds the VERIFY state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam int DEPTH_BYTES_DEFAULT = 256;
  localparam int NUM_LANES           = 4;
  localparam int LANE_W              = $clog2(NUM_LANES);

`ifdef IMEM_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_WRITE     = 3'd2,
    ST_VERIFY    = 3'd3,
    ST_FIN       = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_WRITE     = 3'd2,
    ST_FIN       = 3'd4
  } state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/imem_port_mux.sv
// ============================================================================
// Module  : imem_port_mux
// Brief   : Selects CPU fetch address or loader address/strobe for the memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_mux
  import imem_pkg::*;
(
  input  logic        loader_own,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] loader_addr,
  input  logic        loader_we,
  output logic [31:0] mem_addr,
  output logic        mem_we
);

  always_comb begin
    mem_addr = loader_own ? loader_addr : cpu_pc;
    mem_we   = loader_own & loader_we;
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Streams 32-bit words into a byte-wide instruction memory,
//           big-endian, while stalling the CPU. Optional readback check is
//           enabled by macro IMEM_LOADER_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  output logic             word_ready,
  input  logic [31:0]      cpu_pc,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             cpu_stall,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       lane_addr;
  logic              lane_in_range;
  logic [31:0]       word_shifted;
  logic [31:0]       loader_addr;
  logic              loader_we;
  logic              word_done;

`ifdef IMEM_LOADER_READBACK_EN
  logic              err_q, err_d;
  assign err = err_q;
`else
  logic              unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err          = 1'b0;
`endif

  assign lane_addr     = base_q + 32'(lane_q);
  assign lane_in_range = lane_addr < 32'(DEPTH_BYTES);
  assign word_shifted  = word_q << {lane_q, 3'b000};
  assign cpu_stall     = (state_q != ST_IDLE);
  assign ovf           = ovf_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    word_d      = word_q;
    lane_d      = lane_q;
    ovf_d       = ovf_q;
`ifdef IMEM_LOADER_READBACK_EN
    err_d       = err_q;
`endif
    word_ready  = 1'b0;
    done        = 1'b0;
    loader_addr = base_q;
    loader_we   = 1'b0;
    mem_wdata   = 8'h00;
    word_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = num_words;
          base_d  = '0;
          ovf_d   = 1'b0;
`ifdef IMEM_LOADER_READBACK_EN
          err_d   = 1'b0;
`endif
          state_d = (num_words == '0) ? ST_FIN : ST_WAIT_WORD;
        end
      end
      ST_WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          word_d  = word_data;
          lane_d  = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Out-of-range lanes still consume their cycle; only the strobe is dropped.
        loader_addr = lane_addr;
        loader_we   = lane_in_range;
        mem_wdata   = word_shifted[31:24];
        if (!lane_in_range) ovf_d = 1'b1;
        lane_d = lane_q + 1'b1;
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
`ifdef IMEM_LOADER_READBACK_EN
          state_d = ST_VERIFY;
`else
          word_done = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_READBACK_EN
      ST_VERIFY: begin
        if (mem_rdata != word_q) err_d = 1'b1;
        word_done = 1'b1;
      end
`endif
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_done) begin
      base_d  = base_q + 32'(NUM_LANES);
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_WAIT_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef IMEM_LOADER_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
`ifdef IMEM_LOADER_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  imem_port_mux u_port_mux (
    .loader_own  (cpu_stall),
    .cpu_pc      (cpu_pc),
    .loader_addr (loader_addr),
    .loader_we   (loader_we),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we)
  );

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Randomized self-checking bench for imem_loader with a session-level
//           reference model; honours IMEM_LOADER_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH = 18;
  localparam int CW    = 8;
  localparam int MEMSZ = 256;
`ifdef IMEM_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, word_valid, word_ready, mem_we, cpu_stall, done, ovf, err;
  logic [CW-1:0] num_words;
  logic [31:0]   word_data, cpu_pc, mem_addr, mem_rdata;
  logic [7:0]    mem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_BYTES(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .cpu_pc(cpu_pc), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .done(done), .ovf(ovf), .err(err)
  );

  // Memory written by the DUT, and the image the model says it should hold
  logic [7:0] mem [MEMSZ] = '{default: 8'hEE};
  logic [7:0] img [MEMSZ];
  bit         corrupt2 = 1'b0;

  always @(posedge clk)
    if (mem_we && mem_addr < MEMSZ) mem[mem_addr[7:0]] <= mem_wdata;

  logic [31:0] rd_a;
  logic [7:0]  rd_b;
  always_comb begin
    mem_rdata = '0;
    rd_a      = '0;
    rd_b      = '0;
    for (int k = 0; k < 4; k++) begin
      rd_a = mem_addr + 32'(k);
      rd_b = (rd_a < MEMSZ) ? mem[rd_a[7:0]] : 8'h00;
      if (corrupt2 && rd_a == 32'd2) rd_b = ~rd_b;
      mem_rdata[31-8*k -: 8] = rd_b;
    end
  end

  int cyc = 0;
  int done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  bit          exp_ready, exp_we, exp_stall, exp_done, exp_ovf, exp_err;
  bit          chk_addr, chk_wdata;
  logic [31:0] exp_addr;
  logic [7:0]  exp_wdata;
  bit          m_ovf = 1'b0, m_err = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("word_ready", word_ready, exp_ready);
      check("mem_we", mem_we, exp_we);
      check("cpu_stall", cpu_stall, exp_stall);
      check("done", done, exp_done);
      check("ovf", ovf, exp_ovf);
      check("err", err, exp_err);
      if (chk_addr) check("mem_addr", mem_addr, exp_addr);
      if (chk_wdata) check("mem_wdata", mem_wdata, exp_wdata);
      if (done) done_cyc <= cyc;
    end
  end

  task automatic set_exp(input bit rdy, input bit we, input bit stl, input bit dn,
                         input bit ca, input logic [31:0] a, input bit cw, input logic [7:0] wd);
    exp_ready = rdy; exp_we = we; exp_stall = stl; exp_done = dn;
    chk_addr = ca; exp_addr = a; chk_wdata = cw; exp_wdata = wd;
    exp_ovf = m_ovf; exp_err = m_err;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start      = 1'($urandom_range(0, 1));
    cpu_pc     = $urandom;
    word_valid = 1'($urandom_range(0, 1));
    word_data  = $urandom;
  endtask

  task automatic exp_idle(input bit cw);
    set_exp(0, 0, 0, 0, 1, cpu_pc, cw, 8'h00);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      noise();
      start = 1'b0;
      exp_idle(0);
      step();
    end
  endtask

  function automatic logic [31:0] model_rb(input int base);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      b = img[base+k];
      if (corrupt2 && base + k == 2) b = ~b;
      r[31-8*k -: 8] = b;
    end
    return r;
  endfunction

  // One load session from the IDLE start cycle through FIN (or an injected reset)
  task automatic session(input int n, input logic [31:0] words[$], input int max_gap,
                         input int rst_word, input int rst_lane, output int start_cyc);
    int          base;
    bit          oor;
    logic [31:0] w;
    noise();
    start = 1'b1;
    num_words = CW'(n);
    exp_idle(0);
    start_cyc = cyc;
    step();
    m_ovf = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      base = 4 * i;
      w = words[i];
      repeat ($urandom_range(0, max_gap)) begin
        noise();
        word_valid = 1'b0;
        set_exp(1, 0, 1, 0, 0, 0, 0, 0);
        step();
      end
      noise();
      word_valid = 1'b1;
      word_data = w;
      set_exp(1, 0, 1, 0, 0, 0, 0, 0);
      step();
      for (int k = 0; k < 4; k++) begin
        noise();
        oor = (base + k) >= DEPTH;
        set_exp(0, !oor, 1, 0, 1, 32'(base + k), 1, w[31-8*k -: 8]);
        if (!oor) img[base+k] = w[31-8*k -: 8];
        if (i == rst_word && k == rst_lane) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          m_ovf = 1'b0;
          m_err = 1'b0;
          return;
        end
        step();
        if (oor) m_ovf = 1'b1;
      end
      if (RB) begin
        noise();
        set_exp(0, 0, 1, 0, 1, 32'(base), 0, 0);
        step();
        if (model_rb(base) != w) m_err = 1'b1;
      end
    end
    noise();
    set_exp(0, 0, 1, 1, 0, 0, 0, 0);
    step();
  endtask

  initial begin : main
    logic [31:0] wq[$];
    int          s;
    int          n, rw, rl;
    for (int a = 0; a < MEMSZ; a++) img[a] = 8'hEE;
    rst = 1'b1; start = 1'b0; num_words = '0; word_valid = 1'b0;
    word_data = '0; cpu_pc = 32'h1000;
    step();
    exp_idle(1);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    exp_idle(1);
    step();
    idle_cycles(2);

    // Single word, big-endian byte order
    wq = '{32'h00011020};
    session(1, wq, 0, -1, -1, s);
    idle_cycles(2);
    check("be_byte0", mem[0], 8'h00);
    check("be_byte1", mem[1], 8'h01);
    check("be_byte2", mem[2], 8'h10);
    check("be_byte3", mem[3], 8'h20);
    check("done_lat_1w", done_cyc - s, RB ? 7 : 6);

    // Three words back to back
    wq = '{$urandom, $urandom, $urandom};
    session(3, wq, 0, -1, -1, s);
    idle_cycles(2);
    check("done_lat_3w", done_cyc - s, RB ? 19 : 16);
    for (int a = 0; a < 12; a++) check("mem_3w", mem[a], img[a]);

    // Zero-length session
    session(0, wq, 0, -1, -1, s);
    idle_cycles(2);
    check("done_lat_0w", done_cyc - s, 1);

    // Last word straddles the DEPTH boundary
    wq = '{$urandom, $urandom, $urandom, $urandom, 32'hDEADBEEF};
    session(5, wq, 2, -1, -1, s);
    idle_cycles(2);
    check("ovf_sticky", ovf, 1);
    check("ovf_lane16", mem[16], 8'hDE);
    check("ovf_lane17", mem[17], 8'hAD);
    check("ovf_lane18", mem[18], 8'hEE);
    check("ovf_lane19", mem[19], 8'hEE);

    // Reset in the second write cycle of word 2
    wq = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    session(3, wq, 1, 1, 1, s);
    idle_cycles(2);
    check("rst_byte4", mem[4], 8'h55);
    check("rst_byte5", mem[5], 8'h66);
    check("rst_byte6", mem[6], img[6]);

`ifdef IMEM_LOADER_READBACK_EN
    corrupt2 = 1'b1;
    wq = '{32'h01020304, 32'h05060708};
    session(2, wq, 0, -1, -1, s);
    idle_cycles(1);
    check("rb_err", err, 1);
    check("done_lat_rb", done_cyc - s, 13);
    corrupt2 = 1'b0;
`endif

    // Randomized sessions with occasional mid-session reset
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 6);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      rw = -1;
      rl = -1;
      if (n > 0 && $urandom_range(0, 4) == 0) begin
        rw = $urandom_range(0, n - 1);
        rl = $urandom_range(0, 3);
      end
      session(n, wq, 3, rw, rl, s);
      idle_cycles($urandom_range(1, 3));
    end

    for (int a = 0; a < 32; a++) check("mem_final", mem[a], img[a]);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
- REQ-001: Parameter DEPTH_BYTES, default 256; byte capacity of the instruction memory; addresses at or above it are never written.
- REQ-002: Parameter CNT_W, default 8; width of the word-count input.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: start  input  1  begin a load session; sampled only in IDLE.
- REQ-006: num_words  input  CNT_W  number of words in the session; latched when start is accepted.
- REQ-007: word_valid  input  1  word_data holds a valid instruction word.
- REQ-008: word_data  input  32  instruction word to store.
- REQ-009: word_ready  output  1  loader accepts word_data this cycle.
- REQ-010: cpu_pc  input  32  CPU fetch address.
- REQ-011: mem_addr  output  32  byte address driven to the instruction memory.
- REQ-012: mem_we  output  1  byte write strobe.
- REQ-013: mem_wdata  output  8  byte to write.
- REQ-014: mem_rdata  input  32  big-endian word returned by the memory for mem_addr (combinational).
- REQ-015: cpu_stall  output  1  hold the CPU PC and pipeline.
- REQ-016: done  output  1  one-cycle pulse when a session completes.
- REQ-017: ovf  output  1  sticky flag: a write was suppressed because its address was out of range.
- REQ-018: err  output  1  sticky flag: readback mismatch (only when the readback feature is compiled in).

Function
- REQ-019: The state machine SHALL have the states IDLE, WAIT_WORD, WRITE, VERIFY (macro builds only) and FIN.
- REQ-020: IDLE with start=1: latch num_words, set the base address to 0 and go to WAIT_WORD; if num_words=0, go to FIN instead.
- REQ-021: word_ready SHALL be 1 only in WAIT_WORD; a word is accepted when word_valid and word_ready are both 1, and the state then moves to WRITE.
- REQ-022: WRITE lasts exactly 4 cycles with mem_we=1. Lane k (k=0..3) drives mem_addr=base+k and mem_wdata=word[31-8k:24-8k], so the MSB goes to the lowest address (big-endian).
- REQ-023: After lane 3: base+=4 and the remaining count is decremented. If the count is now 0, go to FIN; otherwise go to WAIT_WORD.
- REQ-024: Throughput SHALL be at least 5 cycles per word (1 accept cycle + 4 write cycles) with word_valid held high.
- REQ-025: A lane address of DEPTH_BYTES or above SHALL force mem_we=0 for that lane and set ovf; sequencing continues unchanged, with no address wrap.
- REQ-026: FIN lasts 1 cycle: done=1, then return to IDLE.
- REQ-027: cpu_stall SHALL be 1 in every state except IDLE.
- REQ-028: In IDLE, mem_addr=cpu_pc and mem_we=0. In all other states the loader owns mem_addr.
- REQ-029: start asserted outside IDLE SHALL be ignored.
- REQ-030: ovf and err SHALL clear only on rst or on an accepted start.

Reset
- REQ-031: On rst=1 at a clock edge, the state becomes IDLE. Outputs are then: word_ready=0, mem_we=0, mem_wdata=0, done=0, ovf=0, err=0, cpu_stall=0, and mem_addr follows cpu_pc.
- REQ-032: rst mid-session SHALL abandon any partial word with no further write strobes. Bytes already written stay in memory.

Configuration
- REQ-033: Macro IMEM_LOADER_READBACK_EN, when defined: after lane 3, enter VERIFY for 1 cycle with mem_addr=base (pre-increment). If mem_rdata differs from the stored word, set err. Then apply REQ-023. Throughput becomes 6 cycles per word.
- REQ-034: When the macro is undefined, there is no VERIFY state, err is tied to 0 and mem_rdata is unused.

Structure
- REQ-035: A shared package imem_pkg SHALL hold the state enum, the DEPTH_BYTES default, and the byte-lane count constant (4).
- REQ-036: The CPU/loader address and write-enable multiplexing SHALL be a sub-module named imem_port_mux.

Verification
- REQ-037: num_words=1, word 0x00011020 -> bytes 0x00,0x01,0x10,0x20 written at addresses 0..3 on 4 consecutive cycles; done 1 cycle later; cpu_stall=0 afterward.
- REQ-038: num_words=3 with word_valid held high -> addresses 0..11 written in order; done on cycle 16 after start is accepted.
- REQ-039: num_words=0 -> no mem_we; done pulses in the cycle after start; cpu_stall high for 1 cycle only.
- REQ-040: DEPTH_BYTES=8, num_words=3 -> bytes at 0..7 written; word 3 gets no strobes; ovf=1; done still pulses.
- REQ-041: rst asserted in the second WRITE cycle of word 2 -> mem_we=0 in the next cycle; state IDLE; mem_addr=cpu_pc; bytes 0..5 remain written.
- REQ-042: With IMEM_LOADER_READBACK_EN defined and a memory model that corrupts address 2 -> err=1 after word 1; the load still completes with done.
